// File: rtl/xup_vector_gate_arbiter.sv
// Round-robin sharing of one SIZE-bit two-input vector gate between two requesters; result after SETTLE_CYCLES.
// One op per SETTLE_CYCLES+2 cycles; requesters hold req until their done pulse, losers simply wait in IDLE.
module xup_vector_gate_arbiter #(
  parameter int SIZE          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] b0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] b1,
  output logic [SIZE-1:0] op_a,
  output logic [SIZE-1:0] op_b,
  input  logic [SIZE-1:0] op_y,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [SIZE-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_served;
  logic          pick1;

  // Port 1 wins when alone, or on contention when port 0 was served last.
  always_comb begin
    pick1 = req1 && (!req0 || !last_served);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      busy        <= 1'b0;
      cnt         <= '0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt0  <= !pick1;
            gnt1  <= pick1;
            op_a  <= pick1 ? a1 : a0;
            op_b  <= pick1 ? b1 : b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            result <= op_y;
            done0  <= gnt0;
            done1  <= gnt1;
            state  <= DONE;
          end
        end
        DONE: begin
          gnt0        <= 1'b0;
          gnt1        <= 1'b0;
          done0       <= 1'b0;
          done1       <= 1'b0;
          busy        <= 1'b0;
          last_served <= gnt1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xup_vector_gate_arbiter.sv
// Directed bench for the shared vector-gate arbiter, with a NOR model on the shared unit.
module tb_xup_vector_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  // DUT with SETTLE_CYCLES=2
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0] op_a, op_b, op_y, result;
  logic       gnt0, gnt1, done0, done1, busy;

  // DUT with SETTLE_CYCLES=1
  logic       s_req0 = 1'b0, s_req1 = 1'b0;
  logic [1:0] s_a0 = '0, s_b0 = '0, s_a1 = '0, s_b1 = '0;
  logic [1:0] s_op_a, s_op_b, s_op_y, s_result;
  logic       s_gnt0, s_gnt1, s_done0, s_done1, s_busy;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit         port;
    logic [1:0] res;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign op_y   = ~(op_a | op_b);
  assign s_op_y = ~(s_op_a | s_op_b);

  xup_vector_gate_arbiter #(.SIZE(2), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op_a(op_a), .op_b(op_b), .op_y(op_y),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy)
  );

  xup_vector_gate_arbiter #(.SIZE(2), .SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .reset(reset), .req0(s_req0), .req1(s_req1),
    .a0(s_a0), .b0(s_b0), .a1(s_a1), .b1(s_b1),
    .op_a(s_op_a), .op_b(s_op_b), .op_y(s_op_y),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .done0(s_done0), .done1(s_done1),
    .result(s_result), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the grant edge; waits for a done pulse and scores it.
  task automatic wait_done(input bit which, input int exp_lat, input string tag);
    int   n = 0;
    logic d0 = 1'b0, d1 = 1'b0;
    exp_t e;
    while (n < 10) begin
      tick();
      n++;
      d0 = which ? s_done0 : done0;
      d1 = which ? s_done1 : done1;
      if (d0 || d1) break;
    end
    check({tag, "_done_seen"}, 32'(d0 | d1), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (d0 || d1) begin
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_done1"}, 32'(d1), 32'(e.port));
        check({tag, "_done0"}, 32'(d0), 32'(!e.port));
        check({tag, "_result"}, 32'(which ? s_result : result), 32'(e.res));
      end
    end
  endtask

  // Done pulses from the two requesters must never overlap.
  always @(negedge clk) begin
    if (mon_en) check("done_overlap", 32'(done0 & done1), 32'd0);
  end

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_op_b", 32'(op_b), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_done", 32'({done0, done1}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s1_result", 32'(s_result), 32'd0);
    mon_en = 1'b1;

    // Single request on port 0
    req0 = 1'b1; a0 = 2'b01; b0 = 2'b00;
    sb.push_back('{port: 1'b0, res: 2'b10});
    tick();
    check("single_gnt0", 32'(gnt0), 32'd1);
    check("single_gnt1", 32'(gnt1), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_op_a", 32'(op_a), 32'h1);
    check("single_op_b", 32'(op_b), 32'h0);
    wait_done(1'b0, 2, "single");
    req0 = 1'b0;
    tick();
    check("single_gnt0_fall", 32'(gnt0), 32'd0);
    check("single_busy_fall", 32'(busy), 32'd0);
    check("single_done_fall", 32'(done0), 32'd0);
    check("idle_op_a_hold", 32'(op_a), 32'h1);
    check("idle_result_hold", 32'(result), 32'h2);

    // Contention right after reset: port 0 first, then port 1 at E0+4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 2'b11; b0 = 2'b00; a1 = 2'b00; b1 = 2'b00;
    sb.push_back('{port: 1'b0, res: 2'b00});
    sb.push_back('{port: 1'b1, res: 2'b11});
    tick();
    check("cont_first_gnt0", 32'(gnt0), 32'd1);
    check("cont_first_gnt1", 32'(gnt1), 32'd0);
    wait_done(1'b0, 2, "cont_p0");
    req0 = 1'b0;
    tick();
    check("cont_gap_gnt", 32'({gnt0, gnt1}), 32'd0);
    tick();
    check("cont_second_gnt1", 32'(gnt1), 32'd1);
    check("cont_second_op_a", 32'(op_a), 32'h0);
    wait_done(1'b0, 2, "cont_p1");
    req1 = 1'b0;
    tick();

    // Fairness: both held high across four transactions
    req0 = 1'b1; req1 = 1'b1;
    a0 = 2'b01; b0 = 2'b00; a1 = 2'b10; b1 = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bit p;
      p = bit'(i % 2);
      sb.push_back('{port: p, res: p ? 2'b01 : 2'b10});
      tick();
      check("fair_gnt0", 32'(gnt0), 32'(!p));
      check("fair_gnt1", 32'(gnt1), 32'(p));
      wait_done(1'b0, 2, "fair");
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Operand change after the grant edge must be ignored
    req0 = 1'b1; a0 = 2'b00; b0 = 2'b00;
    sb.push_back('{port: 1'b0, res: 2'b11});
    tick();
    a0 = 2'b11;
    wait_done(1'b0, 2, "opchg");
    req0 = 1'b0;
    tick();

    // Reset while settling aborts with no done
    req0 = 1'b1; a0 = 2'b01; b0 = 2'b00;
    tick();
    check("abort_gnt0", 32'(gnt0), 32'd1);
    reset = 1'b1;
    req0 = 1'b0;
    tick();
    check("abort_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_op_a", 32'(op_a), 32'd0);
    check("abort_op_b", 32'(op_b), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", 32'({done0, done1}), 32'd0);
      tick();
    end
    req1 = 1'b1; a1 = 2'b10; b1 = 2'b00;
    sb.push_back('{port: 1'b1, res: 2'b01});
    tick();
    check("post_abort_gnt1", 32'(gnt1), 32'd1);
    wait_done(1'b0, 2, "post_abort");
    req1 = 1'b0;
    tick();

    // SETTLE_CYCLES=1 instance
    s_req1 = 1'b1; s_a1 = 2'b10; s_b1 = 2'b00;
    sb.push_back('{port: 1'b1, res: 2'b01});
    tick();
    check("s1_gnt1", 32'(s_gnt1), 32'd1);
    wait_done(1'b1, 1, "s1");
    s_req1 = 1'b0;
    tick();
    check("s1_gnt1_fall", 32'(s_gnt1), 32'd0);
    check("s1_busy_fall", 32'(s_busy), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xup_vector_gate_arbiter.md
# xup_vector_gate_arbiter

Round-robin arbiter and sequencer that shares one SIZE-bit vector logic unit (the library's vector NOR, or any equal-width two-input vector gate) between two requesters. It latches the winning requester's operands onto the shared unit's inputs and waits a programmable settle time that covers the unit's gate delay. It then captures the unit's output and returns it to the requester with a one-cycle done pulse. It sits between lab-level requesters and a single instance of the shared gate vector.

## Interface
- SIZE, 2, operand/result width in bits (≥1)
- SETTLE_CYCLES, 2, clock cycles between driving op_a/op_b and sampling op_y (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  level request; held high until matching done pulse
- a0, b0  in  SIZE  operands of requester 0
- a1, b1  in  SIZE  operands of requester 1
- op_a, op_b  out  SIZE  registered operands to the shared unit
- op_y  in  SIZE  shared unit output
- gnt0, gnt1  out  1  one-hot grant, high for the whole transaction
- done0, done1  out  1  one-cycle result-valid pulse to the granted requester
- result  out  SIZE  captured op_y; holds until the next capture
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not in last_served.
  - At the grant edge: op_a/op_b ← selected operands, gnt set, cnt ← 0, next state SETTLE.
- SETTLE:
  - cnt increments each cycle; width $clog2(SETTLE_CYCLES+1).
  - At the edge where cnt == SETTLE_CYCLES-1: result ← op_y, done of the granted port ← 1, next state DONE.
- DONE:
  - Lasts exactly one cycle; done is high and gnt is still high.
  - Next edge: gnt ← 0, done ← 0, last_served ← granted port, next state IDLE.
- Operands are latched only at the grant edge. Changes on a*/b* after that are ignored.
- req dropped mid-transaction: the transaction still completes and done still pulses. The result is not discarded.
- A req still high in IDLE after its done is treated as a new request. Round robin means the other port wins if it is also requesting.
- op_a/op_b hold their last values in IDLE; they are not cleared.
- Reset (any state, including mid-SETTLE):
  - Next state IDLE.
  - op_a, op_b, result ← 0.
  - gnt0/1, done0/1, busy ← 0.
  - cnt ← 0.
  - last_served ← 1, so port 0 wins the first contention.
  - No done is produced for an aborted transaction.

## Timing
- Grant edge E0: gnt and op_a/op_b are visible after E0; busy goes high after E0.
- Capture edge: E0 + SETTLE_CYCLES. done and result are valid for the cycle after that edge.
- gnt/busy fall at E0 + SETTLE_CYCLES + 1.
- Back-to-back: the earliest next grant edge is E0 + SETTLE_CYCLES + 2, so one IDLE cycle always separates transactions.
- Throughput: one operation per SETTLE_CYCLES+2 cycles.
- op_y must be stable by SETTLE_CYCLES cycles after op_a/op_b change. The block itself adds no combinational path from inputs to outputs.

## Test plan
Bench models op_y = ~(op_a | op_b); SIZE=2, SETTLE_CYCLES=2.

- Single request: req0=1, a0=2'b01, b0=2'b00.
  - gnt0 after E0; op_a=01, op_b=00.
  - done0 pulses for the cycle after E0+2 with result=2'b10.
  - gnt0/busy low after E0+3; done1 never asserts.
- Contention after reset: req0=req1=1 in the same cycle, a0/b0=11/00, a1/b1=00/00.
  - Port 0 is served first: result=00, done0.
  - Port 1 is granted at E0+4: result=11, done1.
- Fairness: hold req0=req1=1 for 4 transactions → grants alternate 0,1,0,1; no done ever overlaps another.
- Operand change mid-SETTLE: a0 changes from 00 to 11 one cycle after grant → result reflects 00|b0 (b0=00 → 11), not the new value.
- Reset mid-SETTLE: assert reset at E0+1.
  - All outputs 0 after that edge; no done pulse.
  - A subsequent req1 alone is granted normally.
- SETTLE_CYCLES=1 build: req1, a1=10, b1=00 → done1 pulses for the cycle after E0+1 with result=01.
